m_store_buffer: RTL and testbench
=================================

// Module: m_store_buffer
// PURPOSE
//   Posted-write buffer between the E/M pipeline register and the data memory write port.
//   Accepts committed stores from the pipeline, queues them in order, drains one per
//   cycle into DM (MWE/addr/MWD/DMWop/PC), and flags loads that hit a pending store word.
//   Removes DM write-port contention from the M-stage critical path; stall only when full.
// PARAMETERS
//   DEPTH    4    number of queued stores; power of two, >= 2
//   PTR_W    2    log2(DEPTH)
// PORTS
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous, active-high reset
//   st_valid     in   1   store request from M stage
//   st_ready     out  1   buffer can accept this cycle
//   st_pc        in   32  PC of store instruction (for DM trace)
//   st_addr      in   32  byte address
//   st_data      in   32  store data, low-aligned (sh: [15:0], sb: [7:0])
//   st_op        in   2   0=sw 1=sh 2=sb (3 treated as sw)
//   st_misalign  out  1   comb: st_valid and address misaligned for st_op
//   ld_valid     in   1   M-stage load probing DM this cycle
//   ld_addr      in   32  load byte address
//   ld_hazard    out  1   comb: load word matches a queued store; pipeline must stall
//   drain_stall  in   1   DM write port unavailable this cycle
//   MWE          out  1   DM write enable
//   PC           out  32  PC of draining store
//   addr         out  32  byte address of draining store
//   MWD          out  32  data of draining store
//   DMWop        out  2   op of draining store
//   sb_empty     out  1   count==0
// BEHAVIOUR
//   - State: DEPTH entries {pc,addr,data,op}, head/tail ptr (PTR_W), count (PTR_W+1).
//   - Reset (async): head=tail=count=0; MWE=0, PC/addr/MWD=0, DMWop=0, st_ready=1,
//     ld_hazard=0, sb_empty=1. Reset mid-operation discards all pending stores.
//   - st_ready = (count < DEPTH); no write-through when full, even if draining same cycle.
//   - Misalign: sw needs addr[1:0]==0, sh needs addr[0]==0, sb never. Misaligned
//     request is NOT enqueued; st_misalign=1 for that cycle; handshake still completes.
//   - Enqueue: st_valid & st_ready & !st_misalign -> write entry[tail], tail++ at edge.
//   - Drain: MWE = (count!=0) & !drain_stall; PC/addr/MWD/DMWop = entry[head] comb.
//     Pop (head++) at the edge where MWE=1. Outputs hold head values when stalled,
//     0 when empty.
//   - Latency: store enqueued at edge N is presented on MWE in cycle N+1 if buffer was
//     empty and no drain_stall. One drain per cycle max.
//   - Simultaneous enqueue+pop: count unchanged; pointers both advance.
//   - Ordering strictly FIFO; stores to same word are never merged or reordered.
//   - ld_hazard = ld_valid & OR over valid entries (addr[31:2]==ld_addr[31:2]); includes
//     the entry draining this cycle (DM read still sees old data); excludes the store
//     being enqueued this cycle.
//   - Pointer wrap: modulo DEPTH; count distinguishes full from empty.
//   - Width: op 3 drains as 3; DM treats it as sw. Addresses passed unmodified.
// STRUCTURE
//   - Shared package: DMWop encodings (SW=0,SH=1,SB=2), DEPTH default, entry struct.
//   - One sub-module: sb_fifo_ctrl (pointers, count, full/empty, push/pop gating);
//     storage, hazard compare and misalign check stay in the top.
// TESTING
//   - Reset: assert reset mid-fill (count=3) -> MWE=0, sb_empty=1, st_ready=1 immediately.
//   - Single sw @0x100 data 0xDEADBEEF -> next cycle MWE=1, addr=0x100, MWD=0xDEADBEEF,
//     DMWop=0; following cycle sb_empty=1.
//   - drain_stall=1, push 4 stores -> st_ready=0 after 4th; 5th held; release stall ->
//     drained in order over 4 cycles, st_ready=1 after first pop.
//   - Enqueue+drain every cycle for 10 stores -> count stays 1, MWE=1 each cycle, order kept.
//   - Queue sb @0x203; load ld_addr=0x200 -> ld_hazard=1; ld_addr=0x204 -> 0; after drain -> 0.
//   - sw @0x102 -> st_misalign=1, not enqueued, sb_empty stays 1; sh @0x102 accepted.

Source files
------------

// File: rtl/m_store_buffer_pkg.sv
// Shared definitions for the posted-write store buffer: DM write-op encodings,
// default depth, the queued-entry layout and the store alignment rule.
package m_store_buffer_pkg;

   localparam int SB_DEPTH = 4;
   localparam int SB_PTR_W = 2;

   // DM write-op encodings; 3 is not defined and is written as a word.
   localparam logic [1:0] OP_SW = 2'd0;
   localparam logic [1:0] OP_SH = 2'd1;
   localparam logic [1:0] OP_SB = 2'd2;

   // One posted store as it will be presented to the DM write port.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  op;
   } sb_entry_t;

   // Alignment rule: halfwords need an even address, bytes are always aligned,
   // words (and the undefined op 3, which DM treats as a word) need addr[1:0]==0.
   function automatic logic store_misaligned(input logic [1:0] op,
                                             input logic [1:0] addr_lo);
      logic bad;
      case (op)
         OP_SH:   bad = addr_lo[0];
         OP_SB:   bad = 1'b0;
         default: bad = (addr_lo != 2'b00);
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/m_store_buffer_sb_fifo_ctrl.sv
// Pointer/occupancy controller for the store buffer. Owns head, tail and count,
// and turns raw push/pop requests into the gated push/pop that actually happen.
// A push is refused whenever the queue is full, even if a pop happens in the
// same cycle, so the storage never needs a write-through path.
module sb_fifo_ctrl
   import m_store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int PTR_W = SB_PTR_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_req,
   input  logic             pop_req,
   output logic             push,
   output logic             pop,
   output logic [PTR_W-1:0] head,
   output logic [PTR_W-1:0] tail,
   output logic [PTR_W:0]   count,
   output logic             full,
   output logic             empty
);

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;

   assign full  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign push  = push_req & ~full;
   assign pop   = pop_req & ~empty;

   assign head  = head_q;
   assign tail  = tail_q;
   assign count = count_q;

   // Next-state: pointers wrap naturally at DEPTH (a power of two); count
   // only moves when exactly one of push/pop happens.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push) begin
         tail_d = tail_q + PTR_W'(1);
      end
      if (pop) begin
         head_d = head_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers; reset empties the queue.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/m_store_buffer.sv
// Posted-write store buffer between the E/M pipeline register and the DM write
// port. Committed stores are queued in order and drained one per cycle; loads
// that touch a word with a pending store are flagged so the pipeline can stall.
//
// Handshakes: a store request transfers in any cycle where st_valid and
// st_ready are both high. A misaligned request still completes its handshake
// but is dropped (st_misalign=1 that cycle). The DM side has no ready: MWE is
// asserted whenever an entry is queued and drain_stall is low, and the head
// entry is popped at that same edge.
module m_store_buffer
   import m_store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int PTR_W = SB_PTR_W
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [31:0] st_pc,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   input  logic [1:0]  st_op,
   output logic        st_misalign,
   input  logic        ld_valid,
   input  logic [31:0] ld_addr,
   output logic        ld_hazard,
   input  logic        drain_stall,
   output logic        MWE,
   output logic [31:0] PC,
   output logic [31:0] addr,
   output logic [31:0] MWD,
   output logic [1:0]  DMWop,
   output logic        sb_empty
);

   logic             push, pop, full, empty;
   logic             push_req, pop_req;
   logic [PTR_W-1:0] head, tail;
   logic [PTR_W:0]   count;

   sb_entry_t entries_q [DEPTH];
   sb_entry_t entries_d [DEPTH];
   sb_entry_t new_entry;
   sb_entry_t head_entry;

   logic [DEPTH-1:0] slot_live;
   logic [DEPTH-1:0] slot_hit;

   // The byte offset within a word never matters for the hazard compare.
   logic unused_ld_lo;
   assign unused_ld_lo = ^ld_addr[1:0];

   // ---------------------------------------------------------------- enqueue
   assign st_misalign = st_valid & store_misaligned(st_op, st_addr[1:0]);
   assign push_req    = st_valid & ~st_misalign;
   assign st_ready    = ~full;

   // Address and op are stored untouched; op 3 drains as 3.
   assign new_entry.pc   = st_pc;
   assign new_entry.addr = st_addr;
   assign new_entry.data = st_data;
   assign new_entry.op   = st_op;

   // ------------------------------------------------------------------ drain
   assign pop_req = ~drain_stall;

   sb_fifo_ctrl #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_ctrl (
      .clk      (clk),
      .reset    (reset),
      .push_req (push_req),
      .pop_req  (pop_req),
      .push     (push),
      .pop      (pop),
      .head     (head),
      .tail     (tail),
      .count    (count),
      .full     (full),
      .empty    (empty)
   );

   // Head entry is presented combinationally; outputs read as zero when empty
   // so DM never sees stale data from a slot that has already drained.
   assign head_entry = entries_q[head];
   assign MWE        = pop;
   assign PC         = empty ? '0 : head_entry.pc;
   assign addr       = empty ? '0 : head_entry.addr;
   assign MWD        = empty ? '0 : head_entry.data;
   assign DMWop      = empty ? '0 : head_entry.op;
   assign sb_empty   = empty;

   // --------------------------------------------------------------- storage
   // Next-state for the entry array: only the tail slot changes, on a push.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         entries_d[i] = entries_q[i];
      end
      if (push) begin
         entries_d[tail] = new_entry;
      end
   end

   // Entry storage; reset clears it so a flushed queue shows no old contents.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= entries_d[i];
         end
      end
   end

   // ---------------------------------------------------------- load hazard
   // A slot is live when its distance from head (mod DEPTH) is below count.
   // The head slot stays live during the cycle it drains, because the DM read
   // in that cycle still returns the pre-store data. The store being enqueued
   // this cycle is not yet in a live slot, so it is excluded by construction.
   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      logic [PTR_W-1:0] ofs;
      assign ofs          = PTR_W'(g) - head;
      assign slot_live[g] = ({1'b0, ofs} < count);
      assign slot_hit[g]  = slot_live[g] &
                            (entries_q[g].addr[31:2] == ld_addr[31:2]);
   end

   assign ld_hazard = ld_valid & (|slot_hit);

endmodule

// File: tb/tb_m_store_buffer.sv
// Bench for m_store_buffer: a table of directed single-cycle vectors with
// hand-derived expectations, a mid-fill reset sequence, a back-to-back stream,
// then randomized traffic checked against a queue-based reference model.
module tb_m_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_pc;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_op;
  logic        st_misalign;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        drain_stall;
  logic        MWE;
  logic [31:0] PC;
  logic [31:0] addr;
  logic [31:0] MWD;
  logic [1:0]  DMWop;
  logic        sb_empty;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        st_valid;
    logic [31:0] st_pc;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_op;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        stall;
    logic        e_ready;
    logic        e_mis;
    logic        e_mwe;
    logic [31:0] e_pc;
    logic [31:0] e_addr;
    logic [31:0] e_mwd;
    logic [1:0]  e_op;
    logic        e_haz;
    logic        e_empty;
  } vec_t;

  // Reference model: pending stores, oldest first, packed as {pc,addr,data,op}.
  logic [97:0] exp_q[$];

  vec_t tbl[$];

  m_store_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_pc       (st_pc),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_op       (st_op),
    .st_misalign (st_misalign),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_hazard   (ld_hazard),
    .drain_stall (drain_stall),
    .MWE         (MWE),
    .PC          (PC),
    .addr        (addr),
    .MWD         (MWD),
    .DMWop       (DMWop),
    .sb_empty    (sb_empty)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mkv(
    input logic sv, input logic [31:0] pc, input logic [31:0] a,
    input logic [31:0] d, input logic [1:0] op, input logic lv,
    input logic [31:0] la, input logic stl,
    input logic r, input logic mis, input logic mwe, input logic [31:0] epc,
    input logic [31:0] ea, input logic [31:0] ed, input logic [1:0] eop,
    input logic haz, input logic emp);
    vec_t v;
    v.st_valid = sv; v.st_pc = pc; v.st_addr = a; v.st_data = d; v.st_op = op;
    v.ld_valid = lv; v.ld_addr = la; v.stall = stl;
    v.e_ready = r; v.e_mis = mis; v.e_mwe = mwe; v.e_pc = epc; v.e_addr = ea;
    v.e_mwd = ed; v.e_op = eop; v.e_haz = haz; v.e_empty = emp;
    return v;
  endfunction

  // Alignment rule stated arithmetically: halfword on even byte, byte anywhere,
  // everything else on a multiple of four.
  function automatic logic rule_misaligned(input logic [1:0] op, input logic [31:0] a);
    if (op == 2'd1) return (a % 2) != 0;
    if (op == 2'd2) return 1'b0;
    return (a % 4) != 0;
  endfunction

  // Fill the expected-output fields of v from the model's current contents.
  function automatic vec_t with_model(input vec_t v);
    vec_t r = v;
    int n = exp_q.size();
    logic [97:0] h;
    r.e_ready = (n < DEPTH);
    r.e_mis   = v.st_valid && rule_misaligned(v.st_op, v.st_addr);
    r.e_mwe   = (n != 0) && !v.stall;
    r.e_empty = (n == 0);
    h = (n != 0) ? exp_q[0] : '0;
    r.e_pc   = h[97:66];
    r.e_addr = h[65:34];
    r.e_mwd  = h[33:2];
    r.e_op   = h[1:0];
    r.e_haz  = 1'b0;
    for (int i = 0; i < n; i++) begin
      logic [97:0] e;
      logic [31:0] ea;
      e  = exp_q[i];
      ea = e[65:34];
      if (v.ld_valid && (ea / 4) == (v.ld_addr / 4)) r.e_haz = 1'b1;
    end
    return r;
  endfunction

  // Advance the model across one clock edge given this cycle's inputs.
  task automatic model_step(input vec_t v);
    int n = exp_q.size();
    logic accept;
    accept = v.st_valid && (n < DEPTH) && !rule_misaligned(v.st_op, v.st_addr);
    if (n != 0 && !v.stall) void'(exp_q.pop_front());
    if (accept) exp_q.push_back({v.st_pc, v.st_addr, v.st_data, v.st_op});
  endtask

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // driver: apply one cycle of inputs after the falling edge, compare mid-low
  // phase, then update the model for the coming rising edge.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    st_valid    = v.st_valid;
    st_pc       = v.st_pc;
    st_addr     = v.st_addr;
    st_data     = v.st_data;
    st_op       = v.st_op;
    ld_valid    = v.ld_valid;
    ld_addr     = v.ld_addr;
    drain_stall = v.stall;
    #2;
    check1({tag, ".st_ready"},    32'(st_ready),    32'(v.e_ready));
    check1({tag, ".st_misalign"}, 32'(st_misalign), 32'(v.e_mis));
    check1({tag, ".MWE"},         32'(MWE),         32'(v.e_mwe));
    check1({tag, ".PC"},          PC,               v.e_pc);
    check1({tag, ".addr"},        addr,             v.e_addr);
    check1({tag, ".MWD"},         MWD,              v.e_mwd);
    check1({tag, ".DMWop"},       32'(DMWop),       32'(v.e_op));
    check1({tag, ".ld_hazard"},   32'(ld_hazard),   32'(v.e_haz));
    check1({tag, ".sb_empty"},    32'(sb_empty),    32'(v.e_empty));
    model_step(v);
  endtask

  vec_t idle_v;

  initial begin
    reset = 1'b1;
    st_valid = 0; st_pc = 0; st_addr = 0; st_data = 0; st_op = 0;
    ld_valid = 0; ld_addr = 0; drain_stall = 0;
    idle_v = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    #12;
    reset = 1'b0;

    // ---- directed table: {inputs | ready mis mwe pc addr mwd op haz empty}
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0,
                      1, 0, 0, 0, 0, 0, 0, 0, 1));                              // reset state
    tbl.push_back(mkv(1, 32'h1000, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0,
                      1, 0, 0, 0, 0, 0, 0, 0, 1));                              // sw 0x100
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0,
                      1, 0, 1, 32'h1000, 32'h100, 32'hDEADBEEF, 0, 0, 0));      // drains next cycle
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0,
                      1, 0, 0, 0, 0, 0, 0, 0, 1));                              // empty again
    tbl.push_back(mkv(1, 32'h1004, 32'h102, 32'h11111111, 0, 0, 0, 0,
                      1, 1, 0, 0, 0, 0, 0, 0, 1));                              // sw 0x102 misaligned
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0,
                      1, 0, 0, 0, 0, 0, 0, 0, 1));                              // nothing enqueued
    tbl.push_back(mkv(1, 32'h1010, 32'h102, 32'h0000BEEF, 1, 0, 0, 0,
                      1, 0, 0, 0, 0, 0, 0, 0, 1));                              // sh 0x102 accepted
    tbl.push_back(mkv(0, 0, 0, 0, 0, 1, 32'h100, 0,
                      1, 0, 1, 32'h1010, 32'h102, 32'h0000BEEF, 1, 1, 0));      // draining entry hazards
    tbl.push_back(mkv(1, 32'h1020, 32'h203, 32'hAB, 2, 1, 32'h200, 1,
                      1, 0, 0, 0, 0, 0, 0, 0, 1));                              // sb 0x203, enqueuing excluded
    tbl.push_back(mkv(0, 0, 0, 0, 0, 1, 32'h200, 1,
                      1, 0, 0, 32'h1020, 32'h203, 32'hAB, 2, 1, 0));            // ld 0x200 hits
    tbl.push_back(mkv(0, 0, 0, 0, 0, 1, 32'h204, 1,
                      1, 0, 0, 32'h1020, 32'h203, 32'hAB, 2, 0, 0));            // ld 0x204 misses
    tbl.push_back(mkv(0, 0, 0, 0, 0, 1, 32'h200, 0,
                      1, 0, 1, 32'h1020, 32'h203, 32'hAB, 2, 1, 0));            // drains, still hazard
    tbl.push_back(mkv(0, 0, 0, 0, 0, 1, 32'h200, 0,
                      1, 0, 0, 0, 0, 0, 0, 0, 1));                              // after drain: no hazard
    tbl.push_back(mkv(1, 32'h1030, 32'h301, 32'h55, 3, 0, 0, 0,
                      1, 1, 0, 0, 0, 0, 0, 0, 1));                              // op3 aligned as word
    tbl.push_back(mkv(1, 32'h1034, 32'h300, 32'h55, 3, 0, 0, 0,
                      1, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0,
                      1, 0, 1, 32'h1034, 32'h300, 32'h55, 3, 0, 0));            // op3 drains as 3
    // fill to DEPTH under drain_stall
    for (int i = 0; i < 4; i++) begin
      tbl.push_back(mkv(1, 32'h2000 + 32'(4*i), 32'h400 + 32'(4*i), 32'hC0DE0000 + 32'(i), 0, 0, 0, 1,
                        1, 0, 0, (i == 0) ? 32'h0 : 32'h2000, (i == 0) ? 32'h0 : 32'h400,
                        (i == 0) ? 32'h0 : 32'hC0DE0000, 0, 0, (i == 0) ? 1'b1 : 1'b0));
    end
    tbl.push_back(mkv(1, 32'h2010, 32'h410, 32'hC0DE0004, 0, 0, 0, 1,
                      0, 0, 0, 32'h2000, 32'h400, 32'hC0DE0000, 0, 0, 0));      // full, 5th held
    tbl.push_back(mkv(1, 32'h2010, 32'h410, 32'hC0DE0004, 0, 0, 0, 0,
                      0, 0, 1, 32'h2000, 32'h400, 32'hC0DE0000, 0, 0, 0));      // no write-through
    tbl.push_back(mkv(1, 32'h2010, 32'h410, 32'hC0DE0004, 0, 0, 0, 0,
                      1, 0, 1, 32'h2004, 32'h404, 32'hC0DE0001, 0, 0, 0));      // ready after first pop
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0,
                      1, 0, 1, 32'h2008, 32'h408, 32'hC0DE0002, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0,
                      1, 0, 1, 32'h200C, 32'h40C, 32'hC0DE0003, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0,
                      1, 0, 1, 32'h2010, 32'h410, 32'hC0DE0004, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0,
                      1, 0, 0, 0, 0, 0, 0, 0, 1));

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // ---- reset mid-fill: three stores held by drain_stall, then async reset
    for (int i = 0; i < 3; i++) begin
      vec_t v;
      v = mkv(1, 32'h3000 + 32'(4*i), 32'h500 + 32'(4*i), 32'h0F0F0000 + 32'(i), 0, 0, 0, 1,
              0, 0, 0, 0, 0, 0, 0, 0, 0);
      run_vec(with_model(v), $sformatf("fill%0d", i));
    end
    @(negedge clk);
    st_valid = 0; ld_valid = 0; drain_stall = 0;
    #1;
    check1("prereset.sb_empty", 32'(sb_empty), 32'(exp_q.size() == 0));
    reset = 1'b1;
    #1;
    check1("rst.MWE",      32'(MWE),      32'(0));
    check1("rst.sb_empty", 32'(sb_empty), 32'(1));
    check1("rst.st_ready", 32'(st_ready), 32'(1));
    check1("rst.MWD",      MWD,           32'h0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    run_vec(with_model(idle_v), "post_rst");

    // ---- enqueue + drain every cycle for 10 stores
    for (int i = 0; i < 10; i++) begin
      vec_t v;
      v = mkv(1, 32'h4000 + 32'(4*i), 32'h600 + 32'(4*i), $urandom, 2'($urandom_range(0, 3)), 0, 0, 0,
              0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.st_addr[1:0] = 2'b00;
      run_vec(with_model(v), $sformatf("stream%0d", i));
      if (i > 0) check1($sformatf("stream%0d.one_pending", i), 32'(exp_q.size()), 32'(1));
    end
    run_vec(with_model(idle_v), "stream_tail");

    // ---- randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      vec_t v;
      v = idle_v;
      v.st_valid = ($urandom_range(0, 2) != 0);
      v.st_pc    = $urandom;
      v.st_addr  = 32'h800 + 32'($urandom_range(0, 23));
      v.st_data  = $urandom;
      v.st_op    = 2'($urandom_range(0, 3));
      v.ld_valid = ($urandom_range(0, 1) == 1);
      v.ld_addr  = 32'h800 + 32'($urandom_range(0, 23));
      v.stall    = ($urandom_range(0, 3) == 0);
      run_vec(with_model(v), $sformatf("rnd%0d", i));
    end
    for (int i = 0; i < DEPTH + 1; i++) run_vec(with_model(idle_v), $sformatf("flush%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
